// File: rtl/i2s_sd_receiver.sv
// I2S / MSB-justified serial-data receiver: finds slots from WS edges, deserializes
// MSB-first words and presents them through a single-entry valid/ready holding register.
module i2s_sd_receiver #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          rx_en,
  input  logic          standard,
  input  logic          frame_size,
  input  logic          stereo,
  input  logic          ws,
  input  logic          sd,
  output logic [DW-1:0] rx_data,
  output logic          rx_chan,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          overflow,
  output logic          short_err,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, CAP_L, CAP_R, SKIP_R} state_t;

  state_t        state, state_nx;
  logic          prev_left, pend_l, pend_r;
  logic          std_q, fs_q, st_q, load_cfg;
  logic [CW-1:0] cnt, cnt_nx, n_bits;
  logic [DW-1:0] sr, sr_nx, first_bit;
  logic          cmp_vld, cmp_vld_nx, cmp_chan, cmp_chan_nx, short_nx;
  logic [DW-1:0] cmp_data, cmp_data_nx;
  logic          msb_mode, is_left, left_raw, right_raw, left_ev, right_ev, capturing;

  // In I2S the slot boundary lags the WS edge by one clock, so the edge is delayed
  // through pend_l/pend_r; from then on both standards share the same datapath.
  assign msb_mode  = (state == IDLE) ? standard : std_q;
  assign is_left   = (ws == msb_mode);
  assign left_raw  = is_left & ~prev_left;
  assign right_raw = ~is_left & prev_left;
  assign left_ev   = msb_mode ? left_raw : pend_l;
  assign right_ev  = msb_mode ? right_raw : pend_r;
  assign capturing = (state == CAP_L) || (state == CAP_R);
  assign n_bits    = fs_q ? CW'(DW) : CW'(DW / 2);
  assign first_bit = {{(DW-1){1'b0}}, sd};
  assign busy      = capturing;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    sr_nx       = sr;
    cmp_vld_nx  = 1'b0;
    cmp_chan_nx = cmp_chan;
    cmp_data_nx = cmp_data;
    short_nx    = 1'b0;
    load_cfg    = 1'b0;
    if (left_ev || (right_ev && state == CAP_L)) begin
      // A slot cut short still yields its bits, MSB-aligned within the slot width.
      if (capturing && cnt != '0 && cnt < n_bits) begin
        cmp_vld_nx  = 1'b1;
        cmp_data_nx = sr << (n_bits - cnt);
        cmp_chan_nx = (state == CAP_R);
        short_nx    = 1'b1;
      end
      cnt_nx = '0;
      sr_nx  = '0;
      if (left_ev) begin
        state_nx = rx_en ? CAP_L : IDLE;
        load_cfg = rx_en;
      end else begin
        state_nx = st_q ? CAP_R : SKIP_R;
      end
      if (state_nx == CAP_L || state_nx == CAP_R) begin
        sr_nx  = first_bit;
        cnt_nx = CW'(1);
      end
    end else if (capturing && cnt < n_bits) begin
      sr_nx  = {sr[DW-2:0], sd};
      cnt_nx = cnt + CW'(1);
      if (cnt == n_bits - CW'(1)) begin
        cmp_vld_nx  = 1'b1;
        cmp_data_nx = sr_nx;
        cmp_chan_nx = (state == CAP_R);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      prev_left <= 1'b0;
      pend_l    <= 1'b0;
      pend_r    <= 1'b0;
      std_q     <= 1'b0;
      fs_q      <= 1'b0;
      st_q      <= 1'b0;
      cnt       <= '0;
      sr        <= '0;
      cmp_vld   <= 1'b0;
      cmp_chan  <= 1'b0;
      cmp_data  <= '0;
      short_err <= 1'b0;
    end else begin
      state     <= state_nx;
      prev_left <= is_left;
      pend_l    <= left_raw;
      pend_r    <= right_raw;
      cnt       <= cnt_nx;
      sr        <= sr_nx;
      cmp_vld   <= cmp_vld_nx;
      cmp_chan  <= cmp_chan_nx;
      cmp_data  <= cmp_data_nx;
      short_err <= short_nx;
      if (load_cfg) begin
        std_q <= standard;
        fs_q  <= frame_size;
        st_q  <= stereo;
      end
    end
  end

  // Holding register: a pop and a load on the same edge leave it full with the new word.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rx_data  <= '0;
      rx_chan  <= 1'b0;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (cmp_vld) begin
        if (rx_valid && !rx_ready) begin
          overflow <= 1'b1;
        end else begin
          rx_data  <= cmp_data;
          rx_chan  <= cmp_chan;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_sd_receiver.sv
// Directed bench for i2s_sd_receiver: table of whole frames plus hand-written
// sequences for back-pressure, rx_en gating and mid-word reset.
module tb_i2s_sd_receiver;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        rx_en = 1'b0, standard = 1'b0, frame_size = 1'b0, stereo = 1'b0;
  logic        ws = 1'b0, sd = 1'b0, rx_ready = 1'b0;
  logic [31:0] rx_data;
  logic        rx_chan, rx_valid, overflow, short_err, busy;

  int compared = 0;
  int mismatched = 0;
  int ovf_cnt = 0;
  int short_cnt = 0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  int base;
  logic cur_std = 1'b0;
  logic prev_bit = 1'b0;

  typedef struct {
    logic        std;
    logic        fs;
    logic        st;
    int          l_len;
    int          l_bits;
    logic [31:0] l_word;
    int          r_len;
    int          r_bits;
    logic [31:0] r_word;
    int          n_exp;
    logic [32:0] exp0;
    logic [32:0] exp1;
    int          exp_short;
  } vec_t;

  vec_t vecs [6];

  i2s_sd_receiver #(.DW(32), .CW(6)) dut (
    .clk(clk), .rst_(rst_), .rx_en(rx_en), .standard(standard),
    .frame_size(frame_size), .stereo(stereo), .ws(ws), .sd(sd),
    .rx_data(rx_data), .rx_chan(rx_chan), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .overflow(overflow), .short_err(short_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Log accepted words and pulse counts, late enough to see this cycle's rx_ready.
  always @(negedge clk) begin
    #2;
    if (rst_) begin
      if (rx_valid && rx_ready) got_q.push_back({rx_chan, rx_data});
      if (overflow) ovf_cnt++;
      if (short_err) short_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // In I2S the line carries each bit one clock after its MSB-justified position.
  task automatic driveCycle(input logic w, input logic b);
    @(negedge clk);
    #1;
    ws = w;
    if (cur_std) sd = b;
    else begin
      sd = prev_bit;
      prev_bit = b;
    end
  endtask

  task automatic sendSlot(input logic lvl, input int len, input int nbits, input logic [31:0] word,
                          input int en_at, input logic en_val);
    logic b;
    for (int i = 0; i < len; i++) begin
      if (i == en_at) rx_en = en_val;
      if (i < nbits) b = word[nbits-1-i];
      else b = 1'b1;
      driveCycle(lvl, b);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst_ = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_ = 1'b1;
    prev_bit = 1'b0;
  endtask

  task automatic checkQueue(input string name);
    int n;
    n = got_q.size() - base;
    checkOutput({name, "_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      checkOutput($sformatf("%s_word%0d", name, i), 64'(got_q[base+i]), 64'(exp_q[i]));
    base = got_q.size();
    exp_q.delete();
  endtask

  task automatic setup(input logic s, input logic f, input logic st, input logic rdy);
    cur_std = s; standard = s; frame_size = f; stereo = st;
    rx_en = 1'b1; rx_ready = rdy; ws = ~s; sd = 1'b0;
    doReset();
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int s0, o0;
    string nm;
    nm = $sformatf("vec%0d", idx);
    setup(v.std, v.fs, v.st, 1'b1);
    checkOutput({nm, "_rst_valid"}, 64'(rx_valid), 64'(0));
    checkOutput({nm, "_rst_data"}, 64'(rx_data), 64'(0));
    checkOutput({nm, "_rst_busy"}, 64'(busy), 64'(0));
    base = got_q.size(); s0 = short_cnt; o0 = ovf_cnt;
    repeat (3) driveCycle(~v.std, 1'b0);
    sendSlot(v.std, v.l_len, v.l_bits, v.l_word, -1, 1'b1);
    sendSlot(~v.std, v.r_len, v.r_bits, v.r_word, -1, 1'b1);
    rx_en = 1'b0;
    repeat (3) driveCycle(v.std, 1'b0);
    repeat (4) driveCycle(~v.std, 1'b0);
    if (v.n_exp > 0) exp_q.push_back(v.exp0);
    if (v.n_exp > 1) exp_q.push_back(v.exp1);
    checkQueue(nm);
    checkOutput({nm, "_short"}, 64'(short_cnt - s0), 64'(v.exp_short));
    checkOutput({nm, "_ovf"}, 64'(ovf_cnt - o0), 64'(0));
    checkOutput({nm, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int o0, s0;
    logic [15:0] rw;
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32, 32, 32'hA5A50F0F, 32, 32, 32'h12345678,
                2, {1'b0, 32'hA5A50F0F}, {1'b1, 32'h12345678}, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32, 16, 32'h0000BEEF, 32, 16, 32'h0000CAFE,
                1, {1'b0, 32'h0000BEEF}, 33'h0, 0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 24, 24, 32'h00ABCDEF, 32, 32, 32'h00000001,
                2, {1'b0, 32'hABCDEF00}, {1'b1, 32'h00000001}, 1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32, 32, 32'hDEADBEEF, 32, 32, 32'h0F1E2D3C,
                2, {1'b0, 32'hDEADBEEF}, {1'b1, 32'h0F1E2D3C}, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16, 16, 32'h00001234, 16, 16, 32'h00008001,
                2, {1'b0, 32'h00001234}, {1'b1, 32'h00008001}, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 20, 16, 32'h00005A5A, 10, 10, 32'h000002A5,
                2, {1'b0, 32'h00005A5A}, {1'b1, 32'h0000A940}, 1};

    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    // Back-pressure: second word dropped with a single overflow pulse, first word kept.
    setup(1'b1, 1'b0, 1'b1, 1'b0);
    base = got_q.size(); o0 = ovf_cnt;
    repeat (3) driveCycle(1'b0, 1'b0);
    sendSlot(1'b1, 16, 16, 32'h1111, -1, 1'b1);
    rw = 16'h2222;
    for (int i = 0; i < 16; i++) begin
      driveCycle(1'b0, rw[15-i]);
      if (i == 0) checkOutput("lat_before", 64'(rx_valid), 64'(0));
      if (i == 1) begin
        checkOutput("lat_valid", 64'(rx_valid), 64'(1));
        checkOutput("lat_data", 64'(rx_data), 64'(32'h1111));
        checkOutput("lat_chan", 64'(rx_chan), 64'(0));
      end
    end
    driveCycle(1'b0, 1'b0);
    checkOutput("ovf_pre", 64'(overflow), 64'(0));
    driveCycle(1'b0, 1'b0);
    checkOutput("ovf_pulse", 64'(overflow), 64'(1));
    driveCycle(1'b0, 1'b0);
    checkOutput("ovf_post", 64'(overflow), 64'(0));
    checkOutput("ovf_keep_data", 64'(rx_data), 64'(32'h1111));
    checkOutput("ovf_keep_valid", 64'(rx_valid), 64'(1));
    rx_ready = 1'b1;
    repeat (2) driveCycle(1'b0, 1'b0);
    checkOutput("pop_valid", 64'(rx_valid), 64'(0));
    checkOutput("ovf_count", 64'(ovf_cnt - o0), 64'(1));
    exp_q.push_back({1'b0, 32'h1111});
    checkQueue("ovf");

    // rx_en dropped mid-frame: this frame completes, then nothing until a fresh left start.
    setup(1'b1, 1'b1, 1'b1, 1'b1);
    base = got_q.size();
    repeat (3) driveCycle(1'b0, 1'b0);
    sendSlot(1'b1, 32, 32, 32'h0F0F0F0F, 5, 1'b0);
    sendSlot(1'b0, 32, 32, 32'hF0F0F0F0, -1, 1'b0);
    sendSlot(1'b1, 32, 32, 32'h11111111, -1, 1'b0);
    checkOutput("en_off_busy", 64'(busy), 64'(0));
    sendSlot(1'b0, 32, 32, 32'h22222222, -1, 1'b0);
    sendSlot(1'b1, 32, 32, 32'h33333333, 3, 1'b1);
    checkOutput("en_late_busy", 64'(busy), 64'(0));
    sendSlot(1'b0, 32, 32, 32'h66666666, -1, 1'b1);
    sendSlot(1'b1, 32, 32, 32'h44444444, -1, 1'b1);
    sendSlot(1'b0, 32, 32, 32'h55555555, -1, 1'b1);
    repeat (4) driveCycle(1'b0, 1'b0);
    exp_q.push_back({1'b0, 32'h0F0F0F0F});
    exp_q.push_back({1'b1, 32'hF0F0F0F0});
    exp_q.push_back({1'b0, 32'h44444444});
    exp_q.push_back({1'b1, 32'h55555555});
    checkQueue("en_gate");

    // Reset at bit 10 of a left word: outputs clear at once, next full left slot is first out.
    setup(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) driveCycle(1'b0, 1'b0);
    sendSlot(1'b1, 32, 32, 32'h89ABCDEF, -1, 1'b1);
    sendSlot(1'b0, 32, 32, 32'h00000000, -1, 1'b1);
    checkOutput("pre_rst_valid", 64'(rx_valid), 64'(1));
    checkOutput("pre_rst_data", 64'(rx_data), 64'(32'h89ABCDEF));
    for (int i = 0; i < 10; i++) driveCycle(1'b1, 1'b1);
    rst_ = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(rx_valid), 64'(0));
    checkOutput("mid_rst_data", 64'(rx_data), 64'(0));
    checkOutput("mid_rst_busy", 64'(busy), 64'(0));
    for (int i = 10; i < 32; i++) driveCycle(1'b1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        rst_ = 1'b1;
        rx_ready = 1'b1;
        base = got_q.size();
        s0 = short_cnt;
      end
      driveCycle(1'b0, 1'b0);
    end
    sendSlot(1'b1, 32, 32, 32'hCAFEBABE, -1, 1'b1);
    sendSlot(1'b0, 32, 32, 32'h01234567, -1, 1'b1);
    repeat (4) driveCycle(1'b0, 1'b0);
    exp_q.push_back({1'b0, 32'hCAFEBABE});
    exp_q.push_back({1'b1, 32'h01234567});
    checkQueue("after_rst");
    checkOutput("after_rst_short", 64'(short_cnt - s0), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
